// File: rtl/fetch_stage_if.sv
// Instruction-memory handshake bundle between the fetch stage (master)
// and a variable-latency instruction memory (slave).
interface fetch_stage_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage: PC, next-PC selection, imem handshake and
// the IF/ID pipeline register.
// Optional macro FETCH_PERF_CNT_EN builds the fetched/stalled counters;
// without it both perf ports read 0.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic         clk,
    input  logic         rst,
    fetch_stage_if.master imem,
    input  logic         stall,
    input  logic         branch_taken,
    input  logic [31:0]  branch_target,
    input  logic         jump,
    output logic [31:0]  pc,
    output logic [31:0]  ifid_instr,
    output logic [31:0]  ifid_pc4,
    output logic         ifid_valid,
    output logic [5:0]   ifid_op,
    output logic [31:0]  perf_fetched,
    output logic [31:0]  perf_stall
);

    typedef enum logic [1:0] {IDLE, REQ, HOLD, DRAIN} state_t;

    state_t      state, state_nxt;
    logic [31:0] pc_nxt, instr_nxt, pc4_nxt;
    logic        valid_nxt;
    logic [31:0] hold_instr, hold_pc4, hold_instr_nxt, hold_pc4_nxt;
    logic [31:0] drain_addr, drain_nxt;
    logic        load_valid;

    logic        redirect;
    logic [31:0] redirect_target;
    logic [31:0] pc_plus4;

    // The branch is older than the jump in IF/ID, so it wins the redirect.
    assign redirect        = branch_taken | jump;
    assign redirect_target = branch_taken ? branch_target
                                          : {ifid_pc4[31:28], ifid_instr[25:0], 2'b00};
    assign pc_plus4        = pc + 32'd4;

    assign imem.imem_req  = (state == REQ) || (state == DRAIN);
    assign imem.imem_addr = (state == DRAIN) ? drain_addr : pc;
    assign ifid_op        = ifid_instr[31:26];

    // Next-state and datapath selection; redirect overrides PC and IF/ID last.
    always_comb begin
        state_nxt      = state;
        pc_nxt         = pc;
        instr_nxt      = ifid_instr;
        pc4_nxt        = ifid_pc4;
        valid_nxt      = ifid_valid;
        hold_instr_nxt = hold_instr;
        hold_pc4_nxt   = hold_pc4;
        drain_nxt      = drain_addr;
        load_valid     = 1'b0;

        case (state)
            IDLE: state_nxt = REQ;
            REQ: begin
                if (redirect) begin
                    // An outstanding request cannot be aborted; wait it out.
                    if (!imem.imem_ready) begin
                        drain_nxt = pc;
                        state_nxt = DRAIN;
                    end
                end else if (imem.imem_ready) begin
                    pc_nxt = pc_plus4;
                    if (stall) begin
                        hold_instr_nxt = imem.imem_rdata;
                        hold_pc4_nxt   = pc_plus4;
                        state_nxt      = HOLD;
                    end else begin
                        instr_nxt  = imem.imem_rdata;
                        pc4_nxt    = pc_plus4;
                        valid_nxt  = 1'b1;
                        load_valid = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (redirect) begin
                    state_nxt = REQ;
                end else if (!stall) begin
                    instr_nxt  = hold_instr;
                    pc4_nxt    = hold_pc4;
                    valid_nxt  = 1'b1;
                    load_valid = 1'b1;
                    state_nxt  = REQ;
                end
            end
            DRAIN: begin
                if (imem.imem_ready) state_nxt = REQ;
            end
            default: state_nxt = IDLE;
        endcase

        if (redirect) begin
            pc_nxt    = redirect_target;
            valid_nxt = 1'b0;
            instr_nxt = '0;
        end
    end

    // State, PC, IF/ID and buffer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            pc         <= RESET_PC;
            ifid_instr <= '0;
            ifid_pc4   <= '0;
            ifid_valid <= 1'b0;
            hold_instr <= '0;
            hold_pc4   <= '0;
            drain_addr <= '0;
        end else begin
            state      <= state_nxt;
            pc         <= pc_nxt;
            ifid_instr <= instr_nxt;
            ifid_pc4   <= pc4_nxt;
            ifid_valid <= valid_nxt;
            hold_instr <= hold_instr_nxt;
            hold_pc4   <= hold_pc4_nxt;
            drain_addr <= drain_nxt;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    // Performance counters: valid IF/ID loads and stalled cycles, wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetched <= '0;
            perf_stall   <= '0;
        end else begin
            if (load_valid)          perf_fetched <= perf_fetched + 32'd1;
            if (stall && ifid_valid) perf_stall   <= perf_stall + 32'd1;
        end
    end
`else
    logic unused_load_valid;
    assign unused_load_valid = load_valid;
    assign perf_fetched      = '0;
    assign perf_stall        = '0;
`endif

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the MIPS datapath, directly upstream of the main control unit. Holds the PC and handshakes with a variable-latency instruction memory. Selects the next PC (sequential, taken branch, jump) and loads the IF/ID pipeline register. `ifid_op` feeds the control unit's 6-bit opcode input.

## Interface

**Parameters**
- `RESET_PC`, default `32'h0000_0000`: first fetch address after reset.

**Ports**
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `imem_req`, output, 1: fetch request; held high until `imem_ready`.
- `imem_addr`, output, 32: fetch address; stable while `imem_req` is high.
- `imem_ready`, input, 1: `imem_rdata` is valid this cycle; completes the request.
- `imem_rdata`, input, 32: fetched instruction word.
- `stall`, input, 1: hazard unit holds IF/ID and the PC.
- `branch_taken`, input, 1: branch resolved taken; redirect to `branch_target`.
- `branch_target`, input, 32: branch destination (computed externally).
- `jump`, input, 1: control unit `J` for the instruction in IF/ID.
- `pc`, output, 32: next fetch address.
- `ifid_instr`, output, 32: IF/ID instruction; `0` is a NOP.
- `ifid_pc4`, output, 32: IF/ID PC+4.
- `ifid_valid`, output, 1: IF/ID holds a real instruction.
- `ifid_op`, output, 6: `ifid_instr[31:26]`, combinational.
- `perf_fetched`, output, 32: count of valid IF/ID loads.
- `perf_stall`, output, 32: count of stalled cycles.

## Operation

**States:** IDLE, REQ, HOLD, DRAIN.
- On `rst`: state IDLE; `pc = RESET_PC`; `imem_req = 0`; `ifid_instr = 0`; `ifid_pc4 = 0`; `ifid_valid = 0`; counters = 0.

**Outputs by state**
- `imem_req = 1` in REQ and DRAIN only.
- `imem_addr = pc` in REQ; `drain_addr` in DRAIN; otherwise `pc`.

**Jump target:** `{ifid_pc4[31:28], ifid_instr[25:0], 2'b00}`.

**Redirect**
- Redirect = `branch_taken | jump`.
- `branch_taken` beats `jump`: the branch is the older instruction.
- Redirect beats `stall`.
- On redirect: `pc <= target`; `ifid_valid <= 0`; `ifid_instr <= 0`.

**Transitions**
- IDLE → REQ, unconditionally (one cycle).
- REQ, `imem_ready`, no redirect, no stall:
  - IF/ID loads `{imem_rdata, pc+4}`, valid = 1.
  - `pc <= pc+4`; stay in REQ.
- REQ, `imem_ready` and `stall`, no redirect:
  - Word goes to the hold buffer; `pc <= pc+4`.
  - IF/ID unchanged; go to HOLD.
- REQ, `imem_ready` with redirect: word dropped; stay in REQ (new `pc`).
- REQ, no `imem_ready`, redirect:
  - `drain_addr <= pc`; go to DRAIN.
  - The outstanding request is never aborted.
- REQ, no `imem_ready`, no redirect: stay in REQ; IF/ID held if `stall`, else IF/ID unchanged.
- HOLD, `!stall`, no redirect: IF/ID loads the hold buffer; go to REQ.
- HOLD with redirect: buffer discarded; go to REQ.
- DRAIN, `imem_ready`: response discarded; go to REQ.
- DRAIN with a further redirect: `pc` updates to the new target; state unchanged.

**Arithmetic:** all PC arithmetic is 32-bit modulo; `32'hFFFF_FFFC + 4` wraps to `0`.

## Timing

- First `imem_req` is in the 2nd cycle after `rst` falls; `imem_addr = RESET_PC`.
- With single-cycle memory (`imem_ready` tied high) and no hazards: one instruction per cycle.
  - IF/ID valid from the 3rd cycle after reset release.
- Memory latency L cycles (request to ready) gives fetch throughput of 1/L.
- Redirect seen at edge N: IF/ID is a bubble after N; first request to the target is at cycle N+1 (REQ) or after the drain completes (DRAIN).
- `rst` asserted mid-request: state forced to IDLE; any later `imem_ready` is ignored. The memory must tolerate a dropped request.

## Configuration

- Macro: `FETCH_PERF_CNT_EN`.
- **Defined:**
  - `perf_fetched` increments on every edge where IF/ID is loaded with valid = 1.
  - `perf_stall` increments on every edge with `stall & ifid_valid`.
  - Both wrap at 2^32.
- **Undefined:** both ports are tied to `0`, no counter flops are built, and behaviour is otherwise identical.

## Test plan

- Reset, `RESET_PC = 32'h0040_0000`, `imem_ready` tied high, sequential words → `imem_addr` steps `0x00400000`, `04`, `08`; `ifid_pc4` follows with a 1-cycle lag; `ifid_valid = 1` from cycle 3.
- `stall` held 3 cycles while `imem_ready` = 1 → state HOLD, IF/ID frozen, `pc` advanced by 4 only once. On release, the buffered word loads with no word lost or duplicated.
- `jump` with `ifid_instr = 32'h0810_0004`, `ifid_pc4 = 32'h0040_0008` → next `imem_addr = 32'h0040_0010`; IF/ID bubble of 1 cycle.
- `branch_taken` (target `0x100`) and `jump` in the same cycle → `pc = 0x100`.
- Memory latency 4, branch taken in the 2nd wait cycle → old address held until ready; that response is discarded; next request goes to the branch target; no stale word reaches IF/ID.
- `FETCH_PERF_CNT_EN` defined, 10 fetches with 2 stall cycles → `perf_fetched = 10`, `perf_stall = 2`. Undefined → both read `0`.
